serial_add_sequencer: RTL and testbench

//   Bit-serial add/subtract controller that time-shares a single 1-bit full-adder

---
 rtl/serial_add_sequencer.sv | 120 ++++++++++++
 tb/tb_serial_add_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract sequencer: one full-adder slice reused LSB-first over WIDTH cycles,
// then a single-cycle DONE pulse with registered result, carry, signed overflow and zero flags.
`default_nettype none

module serial_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic             load;
  logic             last;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit, carry_next;
  logic [WIDTH-1:0] acc_next;

  // The single shared full-adder slice.
  always_comb begin
    sum_bit    = op_a[0] ^ op_b[0] ^ carry;
    carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    acc_next   = {sum_bit, acc[WIDTH-1:1]};
    last       = (cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (load) begin
      // Subtraction as A + ~B + 1: the +1 enters as the initial carry.
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      op_a  <= {1'b0, op_a[WIDTH-1:1]};
      op_b  <= {1'b0, op_b[WIDTH-1:1]};
      carry <= carry_next;
      acc   <= acc_next;
      cnt   <= cnt + 1'b1;
      // On the MSB, carry holds the carry into the MSB; outputs are captured here
      // so they are already valid during the DONE cycle.
      if (last) begin
        result <= acc_next;
        cout   <= carry_next;
        ovf    <= carry ^ carry_next;
        zero   <= (acc_next == '0);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
// Randomized and directed bench for serial_add_sequencer against an integer-arithmetic model.
`default_nettype none

module tb_serial_add_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf, zero;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_res = '0;
  logic         exp_c = 1'b0, exp_v = 1'b0, exp_z = 1'b0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    longint ux, uy, sx, sy, sr;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!s) begin
      exp_res = W'(ux + uy);
      exp_c   = (ux + uy) >= (longint'(1) << W);
      sr      = sx + sy;
    end else begin
      exp_res = W'(ux - uy);
      exp_c   = (ux >= uy);
      sr      = sx - sy;
    end
    exp_v = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
    exp_z = (exp_res == '0);
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".result"}, 32'(result), 32'(exp_res));
    check({tag, ".cout"},   32'(cout),   32'(exp_c));
    check({tag, ".ovf"},    32'(ovf),    32'(exp_v));
    check({tag, ".zero"},   32'(zero),   32'(exp_z));
  endtask

  // Presents an operation for one accepting edge; returns at the negedge of the first RUN cycle.
  task automatic issue(input string tag, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; sub = s; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".held"}, 32'(result), 32'(exp_res));
    model(s, x, y);
  endtask

  // Counts cycles (the first RUN cycle is 1) until DONE, bounded.
  task automatic wait_done(input string tag, input int lat0);
    int lat;
    lat = lat0;
    while (!done && lat < 3*W) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(W + 1));
    check_outs(tag);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(done), 32'd0);
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check({tag, ".nodone"}, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check_outs("rst");
    rst = 1'b0;

    issue("add1", 1'b0, 16'h1234, 16'h0FF1); wait_done("add1", 1);
    issue("addc", 1'b0, 16'hFFFF, 16'h0001); wait_done("addc", 1);
    issue("addv", 1'b0, 16'h7FFF, 16'h0001); wait_done("addv", 1);
    issue("sub1", 1'b1, 16'h0007, 16'h0005); wait_done("sub1", 1);
    issue("sub2", 1'b1, 16'h0005, 16'h0007); wait_done("sub2", 1);
    issue("subv", 1'b1, 16'h8000, 16'h0001); wait_done("subv", 1);
    issue("sub0", 1'b1, 16'hA5A5, 16'h0000); wait_done("sub0", 1);

    // START pulses mid-RUN must be ignored.
    issue("ign", 1'b0, 16'h0102, 16'h0304);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 16'hDEAD; b = 16'hBEEF;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h2222;
    @(negedge clk); start = 1'b0;
    wait_done("ign", 10);
    no_done_for("ign", 2*W);

    // START held through DONE gives back-to-back issue.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    model(1'b0, 16'h0001, 16'h0001);
    wait_done("b2b1", 1);
    start = 1'b0;
    check("b2b2.busy", 32'(busy), 32'd1);
    wait_done("b2b2", 1);

    // Reset mid-RUN aborts with no DONE.
    issue("abort", 1'b0, 16'h4321, 16'h1234);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_res = '0; exp_c = 1'b0; exp_v = 1'b0; exp_z = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check_outs("abort");
    no_done_for("abort", 2*W);
    issue("fresh", 1'b1, 16'h1000, 16'h0001); wait_done("fresh", 1);

    for (int i = 0; i < 40; i++) begin
      logic         s;
      logic [W-1:0] x, y;
      s = 1'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      case ($urandom_range(0, 7))
        0: y = x;
        1: x = 16'h8000;
        2: y = 16'hFFFF;
        default: ;
      endcase
      issue("rand", s, x, y);
      wait_done("rand", 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
